// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The master side issues DIV/DIVU requests; the slave side is the divider.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_div;
    logic [WIDTH-1:0]       opdata1;
    logic [WIDTH-1:0]       opdata2;
    logic                   annul;
    logic                   busy;
    logic                   ready;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  busy, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output busy, ready, result
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
// Result is {remainder, quotient}; busy stalls the pipeline while it works.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      resetn,
    div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIV_ZERO, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        counter_q, counter_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     op1_q, op1_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       trial_rem, trial_diff;
    logic [WIDTH-1:0]     step_rem, step_quo;

    // The trial subtraction carries one extra bit so divisors above 2^(WIDTH-1) still work.
    always_comb begin
        mag1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        mag2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

        trial_rem  = {rem_q, quo_q[WIDTH-1]};
        trial_diff = trial_rem - {1'b0, dsr_q};
        step_rem   = trial_diff[WIDTH] ? trial_rem[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        step_quo   = {quo_q[WIDTH-2:0], ~trial_diff[WIDTH]};

        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        op1_d     = op1_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.annul) begin
                    op1_d     = bus.opdata1;
                    rem_d     = '0;
                    quo_d     = mag1;
                    dsr_d     = mag2;
                    neg_quo_d = bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                    neg_rem_d = bus.signed_div & bus.opdata1[WIDTH-1];
                    counter_d = '0;
                    busy_d    = 1'b1;
                    state_d   = (bus.opdata2 == '0) ? DIV_ZERO : RUN;
                end
            end
            DIV_ZERO: begin
                busy_d = 1'b0;
                if (bus.annul) begin
                    state_d = IDLE;
                end else begin
                    result_d = {op1_q, {WIDTH{1'b1}}};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            RUN: begin
                if (bus.annul) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rem_d     = step_rem;
                    quo_d     = step_quo;
                    counter_d = counter_q + 1'b1;
                    if (counter_q == CW'(WIDTH - 1)) begin
                        result_d = {neg_rem_q ? -step_rem : step_rem,
                                    neg_quo_q ? -step_quo : step_quo};
                        busy_d   = 1'b0;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            op1_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            op1_q     <= op1_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.ready  = ready_q;
    assign bus.result = result_q;
endmodule
